// File: rtl/arbitro_entrada_salida_pkg.sv
// Shared definitions for the I/O port arbiter: FSM states and size constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_arb_pkg;

  // Default widths of the processor I/O port.
  localparam int DIR_W_DEF   = 7;
  localparam int DATO_W_DEF  = 8;

  // Largest supported number of requesters.
  localparam int NUM_REQ_MAX = 8;

  // LIBRE -> ACCESO -> ESPERA -> LIBRE, one full I/O transaction per lap.
  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    ACCESO = 2'd1,
    ESPERA = 2'd2
  } estado_t;

  // Width of an index into a requester vector (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_entrada_salida_if.sv
// Bundle of the requester side and the I/O block side of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold solicitud/escritura/direccion/dato until concesion.
// Ports: slave = arbiter view (takes requests and read data, drives grants,
//        completions and the I/O port); master = requesters plus I/O block.
interface arbitro_entrada_salida_if
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIR_W   = DIR_W_DEF,
  parameter int DATO_W  = DATO_W_DEF
);

  // Requester side
  logic [NUM_REQ-1:0]        solicitud;
  logic [NUM_REQ-1:0]        escritura;
  logic [NUM_REQ*DIR_W-1:0]  direccion;
  logic [NUM_REQ*DATO_W-1:0] dato;
  logic [NUM_REQ-1:0]        concesion;
  logic [NUM_REQ-1:0]        listo;
  logic [DATO_W-1:0]         datoLeido;

  // I/O block side
  logic                      activarEntradaSalida;
  logic                      escribirEntradaSalida;
  logic [DIR_W-1:0]          direccionEntradaSalida;
  logic [DATO_W-1:0]         entradaEntradaSalida;
  logic [DATO_W-1:0]         salidaEntradaSalida;

  modport slave (
    input  solicitud, escritura, direccion, dato, salidaEntradaSalida,
    output concesion, listo, datoLeido,
           activarEntradaSalida, escribirEntradaSalida,
           direccionEntradaSalida, entradaEntradaSalida
  );

  modport master (
    output solicitud, escritura, direccion, dato, salidaEntradaSalida,
    input  concesion, listo, datoLeido,
           activarEntradaSalida, escribirEntradaSalida,
           direccionEntradaSalida, entradaEntradaSalida
  );

endinterface

// File: rtl/arbitro_entrada_salida_selector.sv
// One-hot winner select: first set request found scanning upward from inicio_i, wrapping.
// Latency: combinational.
// Backpressure: none; an empty request vector gives an all-zero grant.
// Ports: req_i request vector, inicio_i scan start index, gnt_o one-hot grant.
module selector_prioridad
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   inicio_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             hallado;
  logic [IDX_W-1:0] idx;
  int               suma;

  always_comb begin
    gnt_o   = '0;
    hallado = 1'b0;
    idx     = '0;
    suma    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate (inicio_i + k) mod NUM_REQ without a divider.
      suma = int'(inicio_i) + k;
      if (suma >= NUM_REQ) begin
        suma = suma - NUM_REQ;
      end
      idx = IDX_W'(suma);
      if (!hallado && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        hallado    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_entrada_salida.sv
// Shares the single processor I/O port between NUM_REQ requesters, one 3-cycle transaction at a time.
// Latency: request in LIBRE at t -> concesion/activar at t+1, listo/datoLeido at t+3.
// Backpressure: requests arriving while busy wait (level-held) until the next LIBRE cycle.
// Ports: clk, reset (sync, active-high), bus (slave modport: requests, grants,
//        completions, read data and the I/O port).
// Build option: IO_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed priority.
module arbitro_entrada_salida
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIR_W   = DIR_W_DEF,
  parameter int DATO_W  = DATO_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  arbitro_entrada_salida_if.slave   bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_fuera_rango
    $error("NUM_REQ must be within 2..NUM_REQ_MAX");
  end

  estado_t             estado_q, estado_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;       // latched winner, one-hot
  logic [NUM_REQ-1:0]  listo_q, listo_d;
  logic                esc_q, esc_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [DATO_W-1:0]   dat_q, dat_d;
  logic [DATO_W-1:0]   leido_q, leido_d;

  logic [NUM_REQ-1:0]  gnt_sel;
  logic [IDX_W-1:0]    inicio;
  logic                sel_esc;
  logic [DIR_W-1:0]    sel_dir;
  logic [DATO_W-1:0]   sel_dat;

`ifdef IO_ARB_ROUND_ROBIN_EN
  // Pointer holds the last winner; the scan starts one past it.
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    sel_idx;

  assign inicio = (ptr_q == IDX_W'(NUM_REQ - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Only moves when a winner is taken, i.e. when a grant will follow.
  always_comb begin
    ptr_d = ptr_q;
    if (estado_q == LIBRE && |bus.solicitud) begin
      ptr_d = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign inicio = '0;
`endif

  selector_prioridad #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_selector (
    .req_i    (bus.solicitud),
    .inicio_i (inicio),
    .gnt_o    (gnt_sel)
  );

  // Winner's operands, selected by the one-hot grant.
  always_comb begin
    sel_esc = 1'b0;
    sel_dir = '0;
    sel_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel[i]) begin
        sel_esc = sel_esc | bus.escritura[i];
        sel_dir = sel_dir | bus.direccion[i*DIR_W +: DIR_W];
        sel_dat = sel_dat | bus.dato[i*DATO_W +: DATO_W];
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    gnt_d    = gnt_q;
    listo_d  = '0;
    esc_d    = esc_q;
    dir_d    = dir_q;
    dat_d    = dat_q;
    leido_d  = leido_q;
    case (estado_q)
      LIBRE: begin
        if (|bus.solicitud) begin
          estado_d = ACCESO;
          gnt_d    = gnt_sel;
          esc_d    = sel_esc;
          dir_d    = sel_dir;
          dat_d    = sel_dat;
        end
      end
      ACCESO: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        estado_d = LIBRE;
        listo_d  = gnt_q;
        if (!esc_q) begin
          leido_d = bus.salidaEntradaSalida;
        end
      end
      default: begin
        estado_d = LIBRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= LIBRE;
      gnt_q    <= '0;
      listo_q  <= '0;
      esc_q    <= 1'b0;
      dir_q    <= '0;
      dat_q    <= '0;
      leido_q  <= '0;
    end else begin
      estado_q <= estado_d;
      gnt_q    <= gnt_d;
      listo_q  <= listo_d;
      esc_q    <= esc_d;
      dir_q    <= dir_d;
      dat_q    <= dat_d;
      leido_q  <= leido_d;
    end
  end

  // Strobe and grant only in ACCESO; port operands hold their last latched values.
  assign bus.activarEntradaSalida   = (estado_q == ACCESO);
  assign bus.concesion              = (estado_q == ACCESO) ? gnt_q : '0;
  assign bus.escribirEntradaSalida  = esc_q;
  assign bus.direccionEntradaSalida = dir_q;
  assign bus.entradaEntradaSalida   = dat_q;
  assign bus.listo                  = listo_q;
  assign bus.datoLeido              = leido_q;

endmodule
